alu_result_deco: RTL and testbench
==================================

Name: alu_result_deco

Overview:
- Result-select stage of the ALU datapath. Receives four precomputed operation results (ADD, SUB, AND, OR) and an ALU control word, and registers the selected one onto the ALU result bus.
- Sits after the parallel functional units and before the writeback/flag logic.
- Produces zero/negative status and an illegal-opcode indication alongside the result.

Parameters:
- WIDTH, 32, width of each operand result and of result.
- CTRL_WIDTH, 32, width of the alu_control word.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  qualifies the inputs this cycle.
- add_res  input  WIDTH  result of the adder.
- sub_res  input  WIDTH  result of the subtractor.
- and_res  input  WIDTH  result of bitwise AND.
- or_res  input  WIDTH  result of bitwise OR.
- alu_control  input  CTRL_WIDTH  operation select code.
- result  output  WIDTH  registered selected result.
- out_valid  output  1  result/flags valid this cycle.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- illegal  output  1  last accepted alu_control was out of range.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). It is sampled on the rising edge of clk only.
- Reset (rst_n=0 at a clk edge) sets:
  - result=0
  - out_valid=0
  - zero=1
  - negative=0
  - illegal=0
- Reset takes priority over in_valid.
- Decode: the full alu_control word is compared, not just the low bits.
  - 0 selects add_res.
  - 1 selects sub_res.
  - 2 selects and_res.
  - 3 selects or_res.
  - Any other value selects 0 and sets illegal=1.
- Latency: 1 cycle. On a clk edge with rst_n=1 and in_valid=1:
  - result gets the selected value.
  - out_valid=1.
  - zero = (selected value == 0).
  - negative = selected value MSB.
  - illegal = decode error.
- in_valid=0 at an edge: result, zero, negative and illegal hold their values; out_valid=0.
- Back-to-back valid inputs are accepted every cycle, with no stall or backpressure.
- No arithmetic in this block: results pass through bit-exact, with no width extension or truncation.
- Flags always reflect the registered result, including the forced 0 on an illegal code (zero=1, negative=0).
- Reset asserted mid-stream discards the input presented that cycle.

Optional Feature:
- Macro: ALU_DECO_BYPASS_EN.
- Defined:
  - result, zero, negative and illegal become combinational from the current inputs (zero latency).
  - out_valid = in_valid & rst_n.
  - Registers are omitted.
  - Decode and flag rules are unchanged.
- Not defined: registered 1-cycle behaviour as specified above.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1 -> result=0, out_valid=0, zero=1, illegal=0.
- Select sweep: add_res=1, sub_res=2, and_res=3, or_res=4, in_valid=1; alu_control=0,1,2,3,1 on consecutive cycles -> result=1,2,3,4,2, each one cycle after its control, out_valid=1 throughout.
- Illegal code: alu_control=5, then 0xFFFFFFFF -> result=0, illegal=1, zero=1; next alu_control=0 -> illegal=0, result=add_res.
- Flags: or_res=0x80000000, alu_control=3 -> negative=1, zero=0; and_res=0, alu_control=2 -> zero=1, negative=0.
- Hold: after result=4, drop in_valid and change alu_control to 0 -> result stays 4, out_valid=0.
- Reset mid-stream: rst_n=0 on the cycle alu_control=1 is presented -> result=0 next cycle, not 2; operation resumes on the first edge with rst_n=1.

Source files
------------

// File: rtl/alu_result_deco.sv
// ALU result-select stage: decodes the full alu_control word, picks one of four results and
// registers it with zero/negative/illegal flags. Define ALU_DECO_BYPASS_EN for a zero-latency path.
module alu_result_deco #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CTRL_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      add_res,
    input  logic [WIDTH-1:0]      sub_res,
    input  logic [WIDTH-1:0]      and_res,
    input  logic [WIDTH-1:0]      or_res,
    input  logic [CTRL_WIDTH-1:0] alu_control,
    output logic [WIDTH-1:0]      result,
    output logic                  out_valid,
    output logic                  zero,
    output logic                  negative,
    output logic                  illegal
);

    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             negative_d;
    logic             illegal_d;

    // The whole control word takes part in the compare, so high garbage bits are illegal.
    always_comb begin
        result_d  = '0;
        illegal_d = 1'b0;
        case (alu_control)
            CTRL_WIDTH'(0): result_d = add_res;
            CTRL_WIDTH'(1): result_d = sub_res;
            CTRL_WIDTH'(2): result_d = and_res;
            CTRL_WIDTH'(3): result_d = or_res;
            default:        illegal_d = 1'b1;
        endcase
        zero_d     = (result_d == '0);
        negative_d = result_d[WIDTH-1];
    end

`ifdef ALU_DECO_BYPASS_EN

    logic unused_clk;
    assign unused_clk = clk;

    assign result    = result_d;
    assign zero      = zero_d;
    assign negative  = negative_d;
    assign illegal   = illegal_d;
    assign out_valid = in_valid & rst_n;

`else

    logic [WIDTH-1:0] result_q;
    logic             valid_q;
    logic             zero_q;
    logic             negative_q;
    logic             illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q   <= '0;
            valid_q    <= 1'b0;
            zero_q     <= 1'b1;
            negative_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            // Without a valid input the result and flags keep describing the last accepted op.
            if (in_valid) begin
                result_q   <= result_d;
                zero_q     <= zero_d;
                negative_q <= negative_d;
                illegal_q  <= illegal_d;
            end
        end
    end

    assign result    = result_q;
    assign out_valid = valid_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign illegal   = illegal_q;

`endif

endmodule

// File: tb/tb_alu_result_deco.sv
// Self-checking bench for alu_result_deco: directed test-plan sequences followed by
// randomized traffic compared against a cycle-level reference model.
module tb_alu_result_deco;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned CTRL_WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic [WIDTH-1:0]      add_res;
    logic [WIDTH-1:0]      sub_res;
    logic [WIDTH-1:0]      and_res;
    logic [WIDTH-1:0]      or_res;
    logic [CTRL_WIDTH-1:0] alu_control;
    logic [WIDTH-1:0]      result;
    logic                  out_valid;
    logic                  zero;
    logic                  negative;
    logic                  illegal;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the stage should be showing after the most recent edge.
    logic [WIDTH-1:0] m_result;
    logic             m_valid;
    logic             m_zero;
    logic             m_negative;
    logic             m_illegal;

    always #5 clk = ~clk;

    alu_result_deco #(
        .WIDTH      (WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .add_res     (add_res),
        .sub_res     (sub_res),
        .and_res     (and_res),
        .or_res      (or_res),
        .alu_control (alu_control),
        .result      (result),
        .out_valid   (out_valid),
        .zero        (zero),
        .negative    (negative),
        .illegal     (illegal)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] s,
                           input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] o);
        add_res = a;
        sub_res = s;
        and_res = n;
        or_res  = o;
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare every output.
    task automatic cycle(input logic rn, input logic iv, input logic [CTRL_WIDTH-1:0] ctrl);
        logic [WIDTH-1:0] ops [4];
        logic [WIDTH-1:0] pick;
        rst_n       = rn;
        in_valid    = iv;
        alu_control = ctrl;
        ops[0] = add_res;
        ops[1] = sub_res;
        ops[2] = and_res;
        ops[3] = or_res;
        @(posedge clk);
        if (!rn) begin
            m_result   = '0;
            m_valid    = 1'b0;
            m_zero     = 1'b1;
            m_negative = 1'b0;
            m_illegal  = 1'b0;
        end else begin
            m_valid = iv;
            if (iv) begin
                m_illegal  = (ctrl > 3);
                pick       = m_illegal ? '0 : ops[ctrl[1:0]];
                m_result   = pick;
                m_zero     = (pick == 0);
                m_negative = (pick >= 32'h8000_0000);
            end
        end
        #1;
        check("result",    result,          m_result);
        check("out_valid", WIDTH'(out_valid), WIDTH'(m_valid));
        check("zero",      WIDTH'(zero),      WIDTH'(m_zero));
        check("negative",  WIDTH'(negative),  WIDTH'(m_negative));
        check("illegal",   WIDTH'(illegal),   WIDTH'(m_illegal));
    endtask

    initial begin
        logic [CTRL_WIDTH-1:0] ctrl;
        int unsigned           r;

        rst_n       = 1'b0;
        in_valid    = 1'b1;
        alu_control = '0;
        set_ops(32'd1, 32'd2, 32'd3, 32'd4);

        // Reset with valid input held high.
        cycle(1'b0, 1'b1, 32'd0);
        cycle(1'b0, 1'b1, 32'd1);
        check("rst_result_const", result, 32'd0);
        check("rst_zero_const",   WIDTH'(zero), 32'd1);

        // Select sweep.
        cycle(1'b1, 1'b1, 32'd0);
        cycle(1'b1, 1'b1, 32'd1);
        cycle(1'b1, 1'b1, 32'd2);
        cycle(1'b1, 1'b1, 32'd3);
        check("sweep_or_const", result, 32'd4);

        // Hold: drop valid and change control.
        cycle(1'b1, 1'b0, 32'd0);
        check("hold_const", result, 32'd4);
        cycle(1'b1, 1'b1, 32'd1);

        // Illegal codes, then recovery.
        cycle(1'b1, 1'b1, 32'd5);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
        check("illegal_const", WIDTH'(illegal), 32'd1);
        cycle(1'b1, 1'b1, 32'h0001_0000);
        cycle(1'b1, 1'b1, 32'd0);
        check("recover_const", result, 32'd1);

        // Flags.
        set_ops(32'd1, 32'd2, 32'd0, 32'h8000_0000);
        cycle(1'b1, 1'b1, 32'd3);
        check("neg_const", WIDTH'(negative), 32'd1);
        cycle(1'b1, 1'b1, 32'd2);

        // Reset mid-stream discards the presented op.
        set_ops(32'd1, 32'd2, 32'd3, 32'd4);
        cycle(1'b1, 1'b1, 32'd0);
        cycle(1'b0, 1'b1, 32'd1);
        check("midrst_const", result, 32'd0);
        cycle(1'b1, 1'b1, 32'd1);
        check("resume_const", result, 32'd2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            set_ops((r == 0) ? 32'd0 : $urandom,
                    (r == 1) ? 32'h8000_0000 : $urandom,
                    (r == 2) ? 32'd0 : $urandom,
                    $urandom);
            r = $urandom_range(0, 9);
            if (r < 7)       ctrl = CTRL_WIDTH'(r % 4);
            else if (r == 7) ctrl = CTRL_WIDTH'($urandom_range(4, 7));
            else if (r == 8) ctrl = CTRL_WIDTH'($urandom);
            else             ctrl = CTRL_WIDTH'(32'h1_0000 << $urandom_range(0, 15)) | CTRL_WIDTH'(r % 4);
            cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), ctrl);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
